uart_receiver: RTL



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart_receiver.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, default framing
// parameters and a parity helper used by both the receiver and the transmitter.
package uart_pkg;

    localparam int UART_DEFAULT_DATA_BITS  = 8;
    localparam int UART_DEFAULT_OVERSAMPLE = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int PARITY_MODE_EVEN = 0;
    localparam int PARITY_MODE_ODD  = 1;

    // Parity bit that makes the frame's count of ones odd (odd=1) or even (odd=0).
    // Narrower words are zero-extended, which leaves the XOR reduction unchanged.
    function automatic logic uart_parity(input logic [7:0] data, input logic odd);
        return odd ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rxd line; resets to the idle level (1).
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: oversampled start/data/parity/stop recovery with a
// valid/ready output word. Parity support is compiled in by UART_RX_PARITY_EN.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = UART_DEFAULT_OVERSAMPLE,
    parameter int PARITY_ODD = PARITY_MODE_ODD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy,
    output logic [2:0]           state_dbg
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
    localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_receiver: DATA_BITS must be 5..8");
    end
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_receiver: OVERSAMPLE must be even and >= 4");
    end
    if (PARITY_ODD != PARITY_MODE_ODD && PARITY_ODD != PARITY_MODE_EVEN) begin : g_bad_parity
        $error("uart_receiver: PARITY_ODD must be 0 or 1");
    end

    logic rxs;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rxd),
        .q     (rxs)
    );

    logic [2:0]           state_q, state_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 armed_q, armed_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 tick_last;
    logic                 word_done;
    logic                 word_ferr;
`ifdef UART_RX_PARITY_EN
    logic                 perr_pend_q, perr_pend_d;
    logic                 perr_q, perr_d;
    logic                 parity_exp;

    assign parity_exp = uart_parity(8'(shift_q), PARITY_ODD != 0);
`endif

    assign tick_last = (tick_cnt_q == TICK_LAST);

    // Frame FSM: everything advances only on rx_tick; IDLE needs a high level
    // (armed) before a falling line counts as a start bit.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        armed_d    = armed_q;
        word_done  = 1'b0;
        word_ferr  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_pend_d = perr_pend_q;
`endif
        if (rx_tick) begin
            case (state_q)
                ST_IDLE: begin
                    tick_cnt_d = '0;
                    if (rxs) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        if (!rxs) begin
                            state_d   = ST_DATA;
                            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                            perr_pend_d = 1'b0;
`endif
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick_last) begin
                        tick_cnt_d = '0;
                        shift_d    = {rxs, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = ST_AFTER_DATA;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick_last) begin
                        tick_cnt_d  = '0;
                        perr_pend_d = (rxs != parity_exp);
                        state_d     = ST_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick_last) begin
                        tick_cnt_d = '0;
                        word_done  = 1'b1;
                        word_ferr  = ~rxs;
                        armed_d    = rxs;
                        state_d    = ST_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    tick_cnt_d = '0;
                end
            endcase
        end
    end

    // Output register: a completed word loads unless an unconsumed word is still
    // held, in which case the new one is dropped and overrun latches.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        if (valid_q && data_ready) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (word_done) begin
            if (!valid_q || data_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                ferr_d  = word_ferr;
`ifdef UART_RX_PARITY_EN
                perr_d  = perr_pend_q;
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            armed_q    <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            armed_q    <= armed_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perr_pend_q <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            perr_pend_q <= perr_pend_d;
            perr_q      <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != ST_IDLE);
    assign state_dbg  = state_q;

endmodule
